cell_circle_render: RTL

CELL_CIRCLE_RENDER -- requirements
Module: cell_circle_render

---
 rtl/cell_circle_render.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/cell_circle_render.sv
`default_nettype none
// ============================================================================
// Module      : cell_circle_render
// Description : Draws a grid of CELLxCELL cells with a red circle centred in
//               the selected cell. Buttons move the selection (with wrap);
//               moves take effect only at the start of vertical sync so the
//               circle never jumps mid-frame. Pixel path is a 2-stage pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module cell_circle_render #(
    parameter int CELL   = 80,
    parameter int COLS   = 8,
    parameter int ROWS   = 6,
    parameter int RADIUS = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       en,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [2:0] cell_col,
    output logic [2:0] cell_row
);

    localparam logic [9:0]  C_HALF    = 10'(CELL / 2);
    localparam logic [9:0]  C_CELL    = 10'(CELL);
    localparam logic [2:0]  C_COL_MAX = 3'(COLS - 1);
    localparam logic [2:0]  C_ROW_MAX = 3'(ROWS - 1);
    localparam logic [21:0] C_R2      = 22'(RADIUS * RADIUS);

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // Selection and move bookkeeping
    logic [2:0]  r_col, r_row;
    logic        r_pend_v;
    dir_t        r_pend_dir;
    logic        r_vs_d;
    logic [9:0]  r_cx, r_cy;

    // Pixel pipeline
    logic signed [10:0] r_dx, r_dy;
    logic        r_grid1, r_en1, r_hs1, r_vs1;
    logic [11:0] r_rgb;
    logic        r_hs2, r_vs2;

    logic        w_btn_any;
    dir_t        w_btn_dir;
    logic        w_apply;
    logic [2:0]  w_col_nxt, w_row_nxt;
    logic        w_grid_x, w_grid_y;
    logic signed [10:0] w_dx, w_dy;
    logic signed [21:0] w_dx2, w_dy2;
    logic [21:0] w_dist;

    assign w_btn_any = btn_up | btn_down | btn_left | btn_right;
    // A move is committed on the clock where vsync is seen low after being high
    assign w_apply   = r_vs_d & ~vsync_in;

    // Priority pick of the incoming button: up > down > left > right
    always_comb begin
        w_btn_dir = DIR_RIGHT;
        if (btn_up)        w_btn_dir = DIR_UP;
        else if (btn_down) w_btn_dir = DIR_DOWN;
        else if (btn_left) w_btn_dir = DIR_LEFT;
    end

    // Selection after applying the pending move, with wrap at the grid edges
    always_comb begin
        w_col_nxt = r_col;
        w_row_nxt = r_row;
        if (r_pend_v) begin
            case (r_pend_dir)
                DIR_UP:    w_row_nxt = (r_row == 3'd0)      ? C_ROW_MAX : r_row - 3'd1;
                DIR_DOWN:  w_row_nxt = (r_row == C_ROW_MAX) ? 3'd0      : r_row + 3'd1;
                DIR_LEFT:  w_col_nxt = (r_col == 3'd0)      ? C_COL_MAX : r_col - 3'd1;
                default:   w_col_nxt = (r_col == C_COL_MAX) ? 3'd0      : r_col + 3'd1;
            endcase
        end
    end

    // Pending-move register, selection registers and latched circle centre
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_col      <= 3'd0;
            r_row      <= 3'd0;
            r_pend_v   <= 1'b0;
            r_pend_dir <= DIR_UP;
            r_vs_d     <= 1'b1;
            r_cx       <= C_HALF;
            r_cy       <= C_HALF;
        end else begin
            r_vs_d <= vsync_in;
            if (w_apply) begin
                r_col <= w_col_nxt;
                r_row <= w_row_nxt;
                r_cx  <= 10'(w_col_nxt) * C_CELL + C_HALF;
                r_cy  <= 10'(w_row_nxt) * C_CELL + C_HALF;
            end
            // A new pulse always wins; otherwise an apply empties the entry
            if (w_btn_any) begin
                r_pend_v   <= 1'b1;
                r_pend_dir <= w_btn_dir;
            end else if (w_apply) begin
                r_pend_v   <= 1'b0;
            end
        end
    end

    // Grid lines: compare against the constant multiples of CELL, no divider
    always_comb begin
        w_grid_x = 1'b0;
        w_grid_y = 1'b0;
        for (int k = 0; k <= COLS; k++) begin
            if (x == 10'(k * CELL)) w_grid_x = 1'b1;
        end
        for (int k = 0; k <= ROWS; k++) begin
            if (y == 10'(k * CELL)) w_grid_y = 1'b1;
        end
    end

    assign w_dx = $signed({1'b0, x}) - $signed({1'b0, r_cx});
    assign w_dy = $signed({1'b0, y}) - $signed({1'b0, r_cy});

    // Stage 1: offsets from the centre, grid flag, enable and syncs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dx    <= '0;
            r_dy    <= '0;
            r_grid1 <= 1'b0;
            r_en1   <= 1'b0;
            r_hs1   <= 1'b1;
            r_vs1   <= 1'b1;
        end else begin
            r_dx    <= w_dx;
            r_dy    <= w_dy;
            r_grid1 <= w_grid_x | w_grid_y;
            r_en1   <= en;
            r_hs1   <= hsync_in;
            r_vs1   <= vsync_in;
        end
    end

    assign w_dx2  = 22'(r_dx) * 22'(r_dx);
    assign w_dy2  = 22'(r_dy) * 22'(r_dy);
    assign w_dist = $unsigned(w_dx2) + $unsigned(w_dy2);

    // Stage 2: colour choice (blank > circle > grid > background) and syncs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rgb <= 12'h000;
            r_hs2 <= 1'b1;
            r_vs2 <= 1'b1;
        end else begin
            r_hs2 <= r_hs1;
            r_vs2 <= r_vs1;
            if (!r_en1)              r_rgb <= 12'h000;
            else if (w_dist <= C_R2) r_rgb <= 12'hF00;
            else if (r_grid1)        r_rgb <= 12'hFFF;
            else                     r_rgb <= 12'h002;
        end
    end

    assign r         = r_rgb[11:8];
    assign g         = r_rgb[7:4];
    assign b         = r_rgb[3:0];
    assign hsync_out = r_hs2;
    assign vsync_out = r_vs2;
    assign cell_col  = r_col;
    assign cell_row  = r_row;

endmodule
`default_nettype wire
